// File: rtl/adder_operand_loader.sv
// adder_operand_loader: collects two operands from a stream and presents them as a pair
//   clk, rst (async, active-high)
//   in_data/in_valid/in_ready : operand stream in (A first, then B)
//   op_a/op_b/op_valid/op_ready : operand pair out to the adder
//   pair_count : pairs delivered, modulo 256
//   timeout_err/clear_err : sticky flag for an A dropped while waiting for B, and its clear
module adder_operand_loader #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             op_valid,
   input  logic             op_ready,
   output logic [7:0]       pair_count,
   output logic             timeout_err,
   input  logic             clear_err
);
   localparam int TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   typedef enum logic [1:0] {LOAD_A, LOAD_B, PRESENT} state_t;
   state_t state, state_nx;
   logic [TW-1:0] timer;
   logic in_hs, out_hs, timeout_hit;
   // rst gates in_ready so nothing is offered while reset is held
   assign in_ready    = !rst && state != PRESENT;
   assign op_valid    = state == PRESENT;
   assign in_hs       = in_valid && in_ready;
   assign out_hs      = op_valid && op_ready;
   // a B arriving on the last wait cycle beats the timeout
   assign timeout_hit = TIMEOUT != 0 && state == LOAD_B && !in_hs && timer == T_LAST;
   always_comb begin
      state_nx = state;
      state_nx = (state == LOAD_A && in_hs) ? LOAD_B :
                 (state == LOAD_B && in_hs) ? PRESENT :
                 (timeout_hit || out_hs)    ? LOAD_A : state;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= LOAD_A;
      else     state <= state_nx;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         op_a        <= '0;
         op_b        <= '0;
         timer       <= '0;
         pair_count  <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == LOAD_A && in_hs) op_a <= in_data;
         if (state == LOAD_B && in_hs) op_b <= in_data;
         if (state == LOAD_A && in_hs) timer <= '0;
         else if (state == LOAD_B && !in_hs && !timeout_hit) timer <= timer + 1'b1;
         if (out_hs) pair_count <= pair_count + 8'd1;
         timeout_err <= timeout_hit ? 1'b1 : clear_err ? 1'b0 : timeout_err;
      end
endmodule

// File: tb/tb_adder_operand_loader.sv
// tb_adder_operand_loader: randomized and directed check of adder_operand_loader against a pair model
module tb_adder_operand_loader;
   localparam int TO = 4;
   logic       clk = 0, rst = 1;
   logic [7:0] in_data = 0;
   logic       in_valid = 0, op_ready = 0, clear_err = 0;
   logic       in_ready, op_valid, timeout_err;
   logic [7:0] op_a, op_b, pair_count;
   int n_chk = 0, n_pass = 0;
   int held = 0, waited = 0;
   logic [7:0] ma = 0, mb = 0, cnt = 0;
   logic err = 0;
   adder_operand_loader #(.WIDTH(8), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
      .pair_count(pair_count), .timeout_err(timeout_err), .clear_err(clear_err)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask
   task automatic model_reset();
      held = 0; waited = 0; ma = 0; mb = 0; cnt = 0; err = 0;
   endtask
   // held counts operands currently owned by the loader: 0, 1 (A) or 2 (pair on offer)
   task automatic model_step(input logic v, input logic [7:0] d, input logic r, input logic c);
      bit to = 0;
      if (held == 2) begin
         if (r) begin held = 0; cnt = cnt + 8'd1; end
      end else if (held == 0) begin
         if (v) begin ma = d; held = 1; waited = 0; end
      end else if (v) begin
         mb = d; held = 2;
      end else if (waited + 1 == TO) begin
         held = 0; to = 1;
      end else waited++;
      err = to ? 1'b1 : c ? 1'b0 : err;
   endtask
   task automatic compare_all();
      check("in_ready", 32'(in_ready), 32'(!rst && held < 2));
      check("op_valid", 32'(op_valid), 32'(held == 2));
      check("op_a", 32'(op_a), 32'(ma));
      check("op_b", 32'(op_b), 32'(mb));
      check("pair_count", 32'(pair_count), 32'(cnt));
      check("timeout_err", 32'(timeout_err), 32'(err));
   endtask
   task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic c);
      in_valid = v; in_data = d; op_ready = r; clear_err = c;
      model_step(v, d, r, c);
      @(posedge clk);
      #1 compare_all();
      @(negedge clk);
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1; in_valid = 0; op_ready = 0; clear_err = 0;
      model_reset();
      #1 compare_all();
      @(negedge clk);
      rst = 0;
   endtask
   initial begin
      @(negedge clk);
      #1 compare_all();
      check("rst_in_ready", 32'(in_ready), 0);
      @(negedge clk);
      rst = 0;
      // basic pair
      cyc(1, 8'h12, 1, 0);
      cyc(1, 8'h34, 1, 0);
      check("basic_valid", 32'(op_valid), 1);
      check("basic_a", 32'(op_a), 32'h12);
      check("basic_b", 32'(op_b), 32'h34);
      cyc(0, 8'h00, 1, 0);
      check("basic_count", 32'(pair_count), 1);
      check("basic_valid_drop", 32'(op_valid), 0);
      // backpressure
      cyc(1, 8'hFF, 0, 0);
      cyc(1, 8'h01, 0, 0);
      for (int i = 0; i < 10; i++) cyc($urandom_range(0, 1), 8'($urandom), 0, 0);
      check("bp_valid", 32'(op_valid), 1);
      check("bp_a", 32'(op_a), 32'hFF);
      check("bp_b", 32'(op_b), 32'h01);
      check("bp_in_ready", 32'(in_ready), 0);
      cyc(0, 8'h00, 1, 0);
      check("bp_in_ready_back", 32'(in_ready), 1);
      // timeout, then clear
      cyc(1, 8'h55, 1, 0);
      for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0);
      check("to_not_yet", 32'(timeout_err), 0);
      cyc(0, 8'h00, 1, 0);
      check("to_err", 32'(timeout_err), 1);
      check("to_a_kept", 32'(op_a), 32'h55);
      check("to_in_ready", 32'(in_ready), 1);
      cyc(0, 8'h00, 1, 1);
      check("to_cleared", 32'(timeout_err), 0);
      // timeout race: B on the last wait cycle wins
      cyc(1, 8'h66, 1, 0);
      for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0);
      cyc(1, 8'h77, 0, 0);
      check("race_valid", 32'(op_valid), 1);
      check("race_b", 32'(op_b), 32'h77);
      check("race_err", 32'(timeout_err), 0);
      cyc(0, 8'h00, 1, 0);
      // pair_count wrap
      do_reset();
      for (int i = 0; i < 256; i++) begin
         cyc(1, 8'($urandom), 1, 0);
         cyc(1, 8'($urandom), 1, 0);
         cyc(1, 8'($urandom), 1, 0);
      end
      check("wrap_256", 32'(pair_count), 0);
      cyc(1, 8'h21, 1, 0);
      cyc(1, 8'h22, 1, 0);
      cyc(0, 8'h00, 1, 0);
      check("wrap_257", 32'(pair_count), 1);
      // randomized traffic including timeouts and clears
      for (int i = 0; i < 600; i++)
         cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1), $urandom_range(0, 7) == 0);
      // async reset while presenting
      cyc(1, 8'hAA, 0, 0);
      cyc(1, 8'hBB, 0, 0);
      check("pre_rst_valid", 32'(op_valid), 1);
      #2 rst = 1;
      #1;
      check("arst_valid", 32'(op_valid), 0);
      check("arst_count", 32'(pair_count), 0);
      check("arst_a", 32'(op_a), 0);
      check("arst_b", 32'(op_b), 0);
      model_reset();
      compare_all();
      @(negedge clk);
      rst = 0;
      cyc(1, 8'h07, 1, 0);
      cyc(1, 8'h09, 1, 0);
      check("post_rst_a", 32'(op_a), 32'h07);
      check("post_rst_b", 32'(op_b), 32'h09);
      cyc(0, 8'h00, 1, 0);
      check("post_rst_count", 32'(pair_count), 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/adder_operand_loader.md
ADDER_OPERAND_LOADER -- requirements
Module: adder_operand_loader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for operand B after operand A; 0 disables the timeout.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  WIDTH  incoming operand byte stream.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader can accept in_data.
REQ-008 op_a  output  WIDTH  operand A to the downstream adder.
REQ-009 op_b  output  WIDTH  operand B to the downstream adder.
REQ-010 op_valid  output  1  op_a/op_b pair valid.
REQ-011 op_ready  input  1  downstream adder accepts the pair.
REQ-012 pair_count  output  8  number of pairs delivered, modulo 256.
REQ-013 timeout_err  output  1  sticky flag: operand A discarded by timeout.
REQ-014 clear_err  input  1  synchronous clear of timeout_err.

Function
REQ-015 The block SHALL implement states LOAD_A, LOAD_B, PRESENT.
REQ-016 Input handshake SHALL complete on a rising edge where in_valid and in_ready are both 1; output handshake where op_valid and op_ready are both 1.
REQ-017 in_ready SHALL be 1 in LOAD_A and LOAD_B, 0 in PRESENT, decoded from state only (no combinational path from op_ready or in_valid).
REQ-018 op_valid SHALL be 1 exactly in PRESENT, decoded from state only.
REQ-019 LOAD_A: on input handshake capture in_data into op_a, clear wait timer to 0, go to LOAD_B.
REQ-020 LOAD_B: on input handshake capture in_data into op_b, go to PRESENT; op_valid SHALL be 1 on the cycle after the B handshake (latency 1).
REQ-021 LOAD_B without handshake: wait timer SHALL increment by 1 per cycle; when TIMEOUT != 0 and timer equals TIMEOUT-1 with no handshake, go to LOAD_A, set timeout_err, leave op_a unchanged.
REQ-022 A B handshake on the timeout cycle SHALL win: pair is completed, no error set.
REQ-023 PRESENT: op_a and op_b SHALL hold stable; on output handshake go to LOAD_A and increment pair_count, wrapping 255 -> 0.
REQ-024 PRESENT with op_ready 0 SHALL hold indefinitely (no timeout in PRESENT).
REQ-025 op_a/op_b SHALL change only on their capture handshakes.
REQ-026 clear_err SHALL clear timeout_err on the next edge; if a timeout occurs in the same cycle, set SHALL win.
REQ-027 Back-to-back pairs SHALL sustain one pair per 3 cycles when in_valid and op_ready are held high.
REQ-028 Wait timer SHALL be wide enough for TIMEOUT (ceil log2(TIMEOUT+1) bits, minimum 1) and SHALL NOT wrap before reaching TIMEOUT-1.

Reset
REQ-029 While rst is 1, state SHALL be LOAD_A, op_a=0, op_b=0, pair_count=0, timeout_err=0, timer=0, op_valid=0, in_ready=0.
REQ-030 Reset asserted mid-operation (LOAD_B or PRESENT) SHALL discard any partial or pending pair immediately, without waiting for a clock edge.
REQ-031 First input handshake SHALL be possible on the first rising edge after rst falls.

Verification
REQ-032 Basic pair: send 0x12 then 0x34 with op_ready=1 -> op_valid 1 for one cycle with op_a=0x12, op_b=0x34; pair_count 0 -> 1.
REQ-033 Backpressure: pair 0xFF, 0x01, op_ready=0 for 10 cycles -> op_valid held, op_a/op_b stable, in_ready=0; then op_ready=1 -> accepted, in_ready returns to 1.
REQ-034 Timeout: TIMEOUT=4, send A=0x55, no B -> after 4 cycles in LOAD_B state returns to LOAD_A, timeout_err=1; clear_err pulse -> timeout_err=0.
REQ-035 Timeout race: TIMEOUT=4, B handshake on the 4th LOAD_B cycle -> pair delivered, timeout_err stays 0.
REQ-036 Wrap: deliver 256 pairs -> pair_count reads 0; 257th pair -> 1.
REQ-037 Async reset: assert rst between clock edges while in PRESENT -> op_valid, pair_count, op_a, op_b go to 0 before the next edge; after release a new pair 0x07, 0x09 is delivered normally.
